// File: rtl/control_sequencer.sv
// Hardwired control unit for a multi-cycle CPU: a T0..T7 timing-state machine
// that decodes the instruction opcode into datapath control strobes each cycle.
module control_sequencer #(
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stop,
    input  logic [DATA_W-1:0] IR,
    input  logic              CON_FF,
    output logic              Gra,
    output logic              Grb,
    output logic              Grc,
    output logic              Rin,
    output logic              Rout,
    output logic              BAout,
    output logic              PCout,
    output logic              PCin,
    output logic              IncPC,
    output logic              MARin,
    output logic              MDRin,
    output logic              MDRout,
    output logic              Read,
    output logic              Write,
    output logic              IRin,
    output logic              Yin,
    output logic              Zin,
    output logic              Zlowout,
    output logic              Cout,
    output logic              CONin,
    output logic              run,
    output logic [3:0]        alu_op
);

    typedef enum logic [3:0] {
        T0, T1, T2, T3, T4, T5, T6, T7, HALT
    } state_t;

    typedef enum logic [2:0] {
        C_ALU, C_IMM, C_LDI, C_LD, C_ST, C_BR, C_NOP, C_HALT
    } iclass_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;

    state_t     state;
    state_t     state_nxt;
    iclass_t    iclass;
    logic [3:0] alu_sel;
    logic [4:0] opcode;
    logic       unused_ir;

    assign opcode    = IR[DATA_W-1 -: 5];
    assign unused_ir = ^IR[DATA_W-6:0];

    // Opcode decode: nop and unknown opcodes share the nop path
    always_comb begin
        iclass  = C_NOP;
        alu_sel = ALU_ADD;
        case (opcode)
            OP_LD:   iclass = C_LD;
            OP_LDI:  iclass = C_LDI;
            OP_ST:   iclass = C_ST;
            OP_ADD:  begin iclass = C_ALU; alu_sel = ALU_ADD; end
            OP_SUB:  begin iclass = C_ALU; alu_sel = ALU_SUB; end
            OP_AND:  begin iclass = C_ALU; alu_sel = ALU_AND; end
            OP_OR:   begin iclass = C_ALU; alu_sel = ALU_OR;  end
            OP_ADDI: begin iclass = C_IMM; alu_sel = ALU_ADD; end
            OP_ANDI: begin iclass = C_IMM; alu_sel = ALU_AND; end
            OP_ORI:  begin iclass = C_IMM; alu_sel = ALU_OR;  end
            OP_BR:   iclass = C_BR;
            OP_HALT: iclass = C_HALT;
            default: iclass = C_NOP;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state <= T0;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = T0;
        case (state)
            T0:   state_nxt = stop ? HALT : T1;
            T1:   state_nxt = T2;
            T2:   state_nxt = T3;
            T3: begin
                case (iclass)
                    C_NOP:   state_nxt = T0;
                    C_HALT:  state_nxt = HALT;
                    default: state_nxt = T4;
                endcase
            end
            T4:   state_nxt = T5;
            T5:   state_nxt = (iclass == C_LD || iclass == C_ST || iclass == C_BR) ? T6 : T0;
            T6:   state_nxt = (iclass == C_LD || iclass == C_ST) ? T7 : T0;
            T7:   state_nxt = T0;
            HALT: state_nxt = HALT;
            default: state_nxt = T0;
        endcase
    end

    // Control strobes; reset forces every strobe low while run stays high
    always_comb begin
        Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
        BAout = 1'b0; PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0;
        MDRin = 1'b0; MDRout = 1'b0; Read = 1'b0; Write = 1'b0; IRin = 1'b0;
        Yin = 1'b0; Zin = 1'b0; Zlowout = 1'b0; Cout = 1'b0; CONin = 1'b0;
        run = 1'b1;
        alu_op = ALU_ADD;
        if (!reset) begin
            case (state)
                T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
                T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
                T2: begin MDRout = 1'b1; IRin = 1'b1; end
                T3: begin
                    case (iclass)
                        C_ALU, C_IMM:      begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                        C_LDI, C_LD, C_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                        C_BR:              begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
                        default: ;
                    endcase
                end
                T4: begin
                    case (iclass)
                        C_ALU:             begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = alu_sel; end
                        C_IMM:             begin Cout = 1'b1; Zin = 1'b1; alu_op = alu_sel; end
                        C_LDI, C_LD, C_ST: begin Cout = 1'b1; Zin = 1'b1; alu_op = ALU_ADD; end
                        C_BR:              begin PCout = 1'b1; Yin = 1'b1; end
                        default: ;
                    endcase
                end
                T5: begin
                    case (iclass)
                        C_ALU, C_IMM, C_LDI: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                        C_LD, C_ST:          begin Zlowout = 1'b1; MARin = 1'b1; end
                        C_BR:                begin Cout = 1'b1; Zin = 1'b1; alu_op = ALU_ADD; end
                        default: ;
                    endcase
                end
                T6: begin
                    case (iclass)
                        C_LD: begin Read = 1'b1; MDRin = 1'b1; end
                        C_ST: begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
                        C_BR: begin Zlowout = 1'b1; PCin = CON_FF; end
                        default: ;
                    endcase
                end
                T7: begin
                    case (iclass)
                        C_LD: begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                        C_ST: Write = 1'b1;
                        default: ;
                    endcase
                end
                HALT: run = 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: per-cycle expected control words queued from a
// reference model of the opcode timing tables and compared at the falling edge.
module tb_control_sequencer;

    typedef struct packed {
        logic Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC, MARin;
        logic MDRin, MDRout, Read, Write, IRin, Yin, Zin, Zlowout, Cout, CONin;
        logic run;
        logic [3:0] alu_op;
    } ctl_t;

    typedef struct {
        logic [4:0] op;
        logic       con;
        int         cycles;
        string      name;
    } vec_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    logic clock = 1'b0;
    logic reset, stop, CON_FF;
    logic [31:0] IR;
    logic Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC, MARin;
    logic MDRin, MDRout, Read, Write, IRin, Yin, Zin, Zlowout, Cout, CONin, run;
    logic [3:0] alu_op;
    ctl_t act;

    int n_checks = 0;
    int n_fail   = 0;

    ctl_t  sb_q[$];
    string nm_q[$];

    control_sequencer #(.DATA_W(32)) dut (
        .clock(clock), .reset(reset), .stop(stop), .IR(IR), .CON_FF(CON_FF),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
        .MDRout(MDRout), .Read(Read), .Write(Write), .IRin(IRin), .Yin(Yin),
        .Zin(Zin), .Zlowout(Zlowout), .Cout(Cout), .CONin(CONin), .run(run),
        .alu_op(alu_op)
    );

    always #5 clock = ~clock;

    assign act = {Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC, MARin,
                  MDRin, MDRout, Read, Write, IRin, Yin, Zin, Zlowout, Cout, CONin,
                  run, alu_op};

    function automatic ctl_t idle_ctl(input logic run_v);
        ctl_t e;
        e = '0;
        e.run = run_v;
        return e;
    endfunction

    // Expected controls for timing step s of opcode op
    function automatic ctl_t exp_ctl(input logic [4:0] op, input int s, input logic con);
        ctl_t e;
        logic r_fmt, i_fmt, ld_like;
        e = '0;
        e.run = 1'b1;
        r_fmt   = (op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_OR);
        i_fmt   = (op == OP_ADDI || op == OP_ANDI || op == OP_ORI);
        ld_like = (op == OP_LD || op == OP_LDI || op == OP_ST);
        case (s)
            0: begin e.PCout = 1; e.MARin = 1; e.IncPC = 1; e.Zin = 1; end
            1: begin e.Zlowout = 1; e.PCin = 1; e.Read = 1; e.MDRin = 1; end
            2: begin e.MDRout = 1; e.IRin = 1; end
            3: begin
                if (r_fmt || i_fmt) begin e.Grb = 1; e.Rout = 1; e.Yin = 1; end
                else if (ld_like)   begin e.Grb = 1; e.BAout = 1; e.Yin = 1; end
                else if (op == OP_BR) begin e.Gra = 1; e.Rout = 1; e.CONin = 1; end
            end
            4: begin
                if (r_fmt) begin
                    e.Grc = 1; e.Rout = 1; e.Zin = 1;
                    e.alu_op = (op == OP_ADD) ? 4'b0000 : (op == OP_SUB) ? 4'b0001 :
                               (op == OP_AND) ? 4'b0010 : 4'b0011;
                end else if (i_fmt) begin
                    e.Cout = 1; e.Zin = 1;
                    e.alu_op = (op == OP_ADDI) ? 4'b0000 : (op == OP_ANDI) ? 4'b0010 : 4'b0011;
                end else if (ld_like) begin
                    e.Cout = 1; e.Zin = 1;
                end else if (op == OP_BR) begin
                    e.PCout = 1; e.Yin = 1;
                end
            end
            5: begin
                if (r_fmt || i_fmt || op == OP_LDI) begin e.Zlowout = 1; e.Gra = 1; e.Rin = 1; end
                else if (op == OP_LD || op == OP_ST) begin e.Zlowout = 1; e.MARin = 1; end
                else if (op == OP_BR) begin e.Cout = 1; e.Zin = 1; end
            end
            6: begin
                if (op == OP_LD)      begin e.Read = 1; e.MDRin = 1; end
                else if (op == OP_ST) begin e.Gra = 1; e.Rout = 1; e.MDRin = 1; end
                else if (op == OP_BR) begin e.Zlowout = 1; e.PCin = con; end
            end
            7: begin
                if (op == OP_LD)      begin e.MDRout = 1; e.Gra = 1; e.Rin = 1; end
                else if (op == OP_ST) e.Write = 1;
            end
            default: ;
        endcase
        return e;
    endfunction

    task automatic check_excl(input string nm);
        n_checks++;
        if ($countones({Rout | BAout, PCout, MDRout, Zlowout, Cout}) > 1 ||
            $countones({Gra, Grb, Grc}) > 1) begin
            n_fail++;
            $display("FAIL excl_%s: got ctl=%h, required at most one bus driver and one register select", nm, act);
        end
    endtask

    // Queue the expectation, compare at the falling edge, return just after the next rising edge
    task automatic cycle(input ctl_t e, input string nm);
        ctl_t  x;
        string n;
        sb_q.push_back(e);
        nm_q.push_back(nm);
        @(negedge clock);
        x = sb_q.pop_front();
        n = nm_q.pop_front();
        n_checks++;
        if (act !== x) begin
            n_fail++;
            $display("FAIL %s: got ctl=%h, expected ctl=%h", n, act, x);
        end
        check_excl(n);
        @(posedge clock);
        #1;
    endtask

    task automatic load_ir(input logic [4:0] op);
        logic [31:0] r;
        r  = $urandom();
        IR = {op, r[26:0]};
    endtask

    task automatic run_instr(input logic [4:0] op, input logic con, input int cycles, input string nm);
        load_ir(op);
        CON_FF = con;
        for (int s = 0; s < cycles; s++)
            cycle(exp_ctl(op, s, con), $sformatf("%s_T%0d", nm, s));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test, required completion within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl[15];
        tbl[0]  = '{OP_ADD,  1'b0, 6, "add"};
        tbl[1]  = '{OP_SUB,  1'b0, 6, "sub"};
        tbl[2]  = '{OP_AND,  1'b0, 6, "and"};
        tbl[3]  = '{OP_OR,   1'b0, 6, "or"};
        tbl[4]  = '{OP_ADDI, 1'b0, 6, "addi"};
        tbl[5]  = '{OP_ANDI, 1'b0, 6, "andi"};
        tbl[6]  = '{OP_ORI,  1'b0, 6, "ori"};
        tbl[7]  = '{OP_LDI,  1'b0, 6, "ldi"};
        tbl[8]  = '{OP_LD,   1'b0, 8, "ld"};
        tbl[9]  = '{OP_ST,   1'b1, 8, "st"};
        tbl[10] = '{OP_BR,   1'b1, 7, "br_taken"};
        tbl[11] = '{OP_BR,   1'b0, 7, "br_not_taken"};
        tbl[12] = '{OP_NOP,  1'b1, 4, "nop"};
        tbl[13] = '{5'b11111, 1'b0, 4, "undef_11111"};
        tbl[14] = '{5'b10101, 1'b0, 4, "undef_10101"};

        reset = 1'b1; stop = 1'b0; CON_FF = 1'b0; IR = '0;
        cycle(idle_ctl(1'b1), "reset_hold0");
        cycle(idle_ctl(1'b1), "reset_hold1");
        reset = 1'b0;

        // Each instruction's T0 check also confirms the previous one's latency
        for (int i = 0; i < 15; i++)
            run_instr(tbl[i].op, tbl[i].con, tbl[i].cycles, tbl[i].name);

        // stop pulse outside T0 is ignored
        load_ir(OP_ADD);
        for (int s = 0; s < 6; s++) begin
            stop = (s == 4);
            cycle(exp_ctl(OP_ADD, s, 1'b0), $sformatf("stop_t4_T%0d", s));
        end
        stop = 1'b0;

        // stop in T0: T0 strobes that cycle, then HALT until reset with stop ignored
        stop = 1'b1;
        cycle(exp_ctl(OP_ADD, 0, 1'b0), "stop_t0");
        for (int k = 0; k < 12; k++) begin
            stop = k[0];
            cycle(idle_ctl(1'b0), $sformatf("halt_hold%0d", k));
        end
        stop = 1'b0;
        reset = 1'b1;
        cycle(idle_ctl(1'b1), "reset_from_halt");
        reset = 1'b0;

        // halt opcode
        run_instr(OP_HALT, 1'b0, 4, "halt_op");
        for (int k = 0; k < 3; k++)
            cycle(idle_ctl(1'b0), $sformatf("halt_op_hold%0d", k));
        reset = 1'b1;
        cycle(idle_ctl(1'b1), "reset_from_halt_op");
        reset = 1'b0;

        // reset during st T6: Write must never appear
        load_ir(OP_ST);
        for (int s = 0; s < 6; s++)
            cycle(exp_ctl(OP_ST, s, 1'b0), $sformatf("st_rst_T%0d", s));
        reset = 1'b1;
        cycle(idle_ctl(1'b1), "st_rst_in_T6");
        cycle(idle_ctl(1'b1), "st_rst_hold");
        reset = 1'b0;
        run_instr(OP_ADD, 1'b0, 6, "after_rst_add");
        cycle(exp_ctl(OP_NOP, 0, 1'b0), "final_T0");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
